// File: rtl/fp_pkg.sv
// Shared FP types and helpers for the multiplier exception stage.
// Helpers take field widths as arguments so one package serves every EXP_W/MAN_W.
package fp_pkg;

    typedef enum logic [2:0] {
        IEEE_NEAR = 3'd0,
        IEEE_ZERO = 3'd1,
        IEEE_PINF = 3'd2,
        IEEE_NINF = 3'd3,
        NEAR_UP   = 3'd4,
        AWAY_ZERO = 3'd5
    } round_t;

    typedef enum logic [1:0] {ZERO, INF, NAN, NORM} fp_class_t;

    typedef enum logic [2:0] {SP_ZERO, SP_INF, SP_QNAN, SP_MAX_NORM, SP_MIN_NORM} fp_special_t;

    localparam int FP_MAX_W = 128;
    typedef logic [FP_MAX_W-1:0] fp_word_t;

    // Subnormals (exp==0, man!=0) deliberately classify as ZERO: they are flushed.
    function automatic fp_class_t classify(input logic exp_zero, input logic exp_ones,
                                           input logic man_zero);
        if (exp_zero)
            return ZERO;
        if (exp_ones)
            return man_zero ? INF : NAN;
        return NORM;
    endfunction

    // Magnitude (everything below the sign bit) of a special value.
    function automatic fp_word_t fp_special_mag(input fp_special_t kind, input int exp_w,
                                                input int man_w);
        fp_word_t ones_e;
        fp_word_t ones_m;
        fp_word_t e;
        fp_word_t m;
        ones_e = (fp_word_t'(1) << exp_w) - fp_word_t'(1);
        ones_m = (fp_word_t'(1) << man_w) - fp_word_t'(1);
        e      = '0;
        m      = '0;
        case (kind)
            SP_INF:      e = ones_e;
            SP_QNAN: begin
                e = ones_e;
                m = fp_word_t'(1) << (man_w - 1);
            end
            SP_MAX_NORM: begin
                e = ones_e - fp_word_t'(1);
                m = ones_m;
            end
            SP_MIN_NORM: e = fp_word_t'(1);
            default: ;
        endcase
        return (e << man_w) | m;
    endfunction

endpackage

// File: rtl/fp_mult_exception_pipe_select.sv
// Combinational classify, special-case priority and rounding-mode override of the product.
// Latency 0; no flow control of its own.
module fp_mult_exception_pipe_select
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic [EXP_W+MAN_W:0] z_calc,
    input  logic [2:0]           round,
    input  logic                 ovf,
    input  logic                 unf,
    input  logic                 inexact,
    output logic [EXP_W+MAN_W:0] z,
    output logic                 zero_f,
    output logic                 inf_f,
    output logic                 nan_f,
    output logic                 tiny_f,
    output logic                 huge_f,
    output logic                 inexact_f
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int MAG_W = W - 1;
    localparam logic [MAG_W-1:0] INF_MAG  = MAG_W'(fp_special_mag(SP_INF, EXP_W, MAN_W));
    localparam logic [MAG_W-1:0] QNAN_MAG = MAG_W'(fp_special_mag(SP_QNAN, EXP_W, MAN_W));
    localparam logic [MAG_W-1:0] MAX_MAG  = MAG_W'(fp_special_mag(SP_MAX_NORM, EXP_W, MAN_W));
    localparam logic [MAG_W-1:0] MIN_MAG  = MAG_W'(fp_special_mag(SP_MIN_NORM, EXP_W, MAN_W));

    fp_class_t ca;
    fp_class_t cb;
    logic      sign;

    assign sign = a[W-1] ^ b[W-1];
    assign ca   = classify(a[W-2:MAN_W] == '0, &a[W-2:MAN_W], a[MAN_W-1:0] == '0);
    assign cb   = classify(b[W-2:MAN_W] == '0, &b[W-2:MAN_W], b[MAN_W-1:0] == '0);

    always_comb begin
        z         = z_calc;
        nan_f     = 1'b0;
        tiny_f    = 1'b0;
        huge_f    = 1'b0;
        inexact_f = 1'b0;
        if (ca == NAN || cb == NAN || (ca == INF && cb == ZERO) || (ca == ZERO && cb == INF)) begin
            z     = {1'b0, QNAN_MAG};
            nan_f = 1'b1;
        end else if (ca == INF || cb == INF) begin
            z = {sign, INF_MAG};
        end else if (ca == ZERO || cb == ZERO) begin
            z = {sign, {MAG_W{1'b0}}};
        end else begin
            huge_f    = ovf;
            tiny_f    = unf & ~ovf;
            inexact_f = inexact;
            if (ovf) begin
                case (round)
                    IEEE_ZERO: z = {sign, MAX_MAG};
                    IEEE_PINF: z = {sign, sign ? MAX_MAG : INF_MAG};
                    IEEE_NINF: z = {sign, sign ? INF_MAG : MAX_MAG};
                    default:   z = {sign, INF_MAG};
                endcase
            end else if (unf) begin
                case (round)
                    AWAY_ZERO: z = {sign, MIN_MAG};
                    IEEE_PINF: z = {sign, sign ? {MAG_W{1'b0}} : MIN_MAG};
                    IEEE_NINF: z = {sign, sign ? MIN_MAG : {MAG_W{1'b0}}};
                    default:   z = {sign, {MAG_W{1'b0}}};
                endcase
            end
        end
    end

    // Derived from the final value so overrides and pass-through are covered alike.
    assign inf_f  = (z[W-2:0] == INF_MAG);
    assign zero_f = (z[W-2:0] == '0);

endmodule

// File: rtl/fp_mult_exception_pipe.sv
// Registered FP multiplier exception stage with sticky flags and a saturating exception counter.
// Latency 1, full throughput; in_ready drops only while a held result is not taken downstream.
module fp_mult_exception_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic [EXP_W+MAN_W:0] z_calc,
    input  logic [2:0]           round,
    input  logic                 ovf,
    input  logic                 unf,
    input  logic                 inexact,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] z,
    output logic                 zero_f,
    output logic                 inf_f,
    output logic                 nan_f,
    output logic                 tiny_f,
    output logic                 huge_f,
    output logic                 inexact_f,
    input  logic                 sticky_clr,
    output logic [5:0]           sticky,
    output logic [CNT_W-1:0]     exc_cnt
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic [W-1:0] sel_z;
    logic [5:0]   sel_flags;
    logic [5:0]   cur_flags;
    logic         accept;
    logic         out_hs;
    logic         exc_evt;

    fp_mult_exception_pipe_select #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_select (
        .a         (a),
        .b         (b),
        .z_calc    (z_calc),
        .round     (round),
        .ovf       (ovf),
        .unf       (unf),
        .inexact   (inexact),
        .z         (sel_z),
        .zero_f    (sel_flags[3]),
        .inf_f     (sel_flags[4]),
        .nan_f     (sel_flags[5]),
        .tiny_f    (sel_flags[2]),
        .huge_f    (sel_flags[1]),
        .inexact_f (sel_flags[0])
    );

    assign in_ready  = ~out_valid | out_ready;
    assign accept    = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;
    assign cur_flags = {nan_f, inf_f, zero_f, tiny_f, huge_f, inexact_f};
    assign exc_evt   = out_hs & (nan_f | huge_f | tiny_f);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            z         <= '0;
            {nan_f, inf_f, zero_f, tiny_f, huge_f, inexact_f} <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            z         <= sel_z;
            {nan_f, inf_f, zero_f, tiny_f, huge_f, inexact_f} <= sel_flags;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A clear coinciding with a handshake keeps that result's contribution.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky  <= '0;
            exc_cnt <= '0;
        end else begin
            if (sticky_clr)
                sticky <= out_hs ? cur_flags : 6'd0;
            else if (out_hs)
                sticky <= sticky | cur_flags;

            if (sticky_clr)
                exc_cnt <= exc_evt ? CNT_W'(1) : '0;
            else if (exc_evt && exc_cnt != '1)
                exc_cnt <= exc_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fp_mult_exception_pipe.sv
// Directed-vector bench for fp_mult_exception_pipe (binary32 configuration).
module tb_fp_mult_exception_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b, z_calc;
    logic [2:0]  round;
    logic        ovf, unf, inexact;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;
    logic        zero_f, inf_f, nan_f, tiny_f, huge_f, inexact_f;
    logic        sticky_clr;
    logic [5:0]  sticky;
    logic [15:0] exc_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fp_mult_exception_pipe #(.EXP_W(8), .MAN_W(23), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .z_calc(z_calc), .round(round),
        .ovf(ovf), .unf(unf), .inexact(inexact),
        .out_valid(out_valid), .out_ready(out_ready), .z(z),
        .zero_f(zero_f), .inf_f(inf_f), .nan_f(nan_f), .tiny_f(tiny_f),
        .huge_f(huge_f), .inexact_f(inexact_f),
        .sticky_clr(sticky_clr), .sticky(sticky), .exc_cnt(exc_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] flags();
        return {nan_f, inf_f, zero_f, tiny_f, huge_f, inexact_f};
    endfunction

    // One transaction: drive, register, then check the output at the following negedge.
    task automatic run_one(input string tag, input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] vz, input logic [2:0] vr, input logic vo,
                           input logic vu, input logic vi, input logic [31:0] exp_z,
                           input logic [5:0] exp_f);
        @(negedge clk);
        a = va; b = vb; z_calc = vz; round = vr; ovf = vo; unf = vu; inexact = vi;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".z"}, 64'(z), 64'(exp_z));
        check({tag, ".flags"}, 64'(flags()), 64'(exp_f));
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          sent;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sticky_clr = 1'b0;
        a = '0; b = '0; z_calc = '0; round = '0; ovf = 1'b0; unf = 1'b0; inexact = 1'b0;
        #12;
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.z", 64'(z), 64'd0);
        check("rst.flags", 64'(flags()), 64'd0);
        check("rst.sticky", 64'(sticky), 64'd0);
        check("rst.cnt", 64'(exc_cnt), 64'd0);
        @(negedge clk) rst = 1'b0;
        check("rst.in_ready", 64'(in_ready), 64'd1);

        // flags order: {nan, inf, zero, tiny, huge, inexact}
        run_one("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h0, 3'd0, 0, 0, 0, 32'h7FC00000, 6'b100000);
        run_one("nan_prop",   32'h7FC00001, 32'h3F800000, 32'h0, 3'd0, 0, 0, 0, 32'h7FC00000, 6'b100000);
        run_one("neg_inf",    32'hFF800000, 32'h3F800000, 32'h0, 3'd0, 0, 0, 0, 32'hFF800000, 6'b010000);
        run_one("neg_zero",   32'h80000000, 32'h40000000, 32'h0, 3'd0, 0, 0, 0, 32'h80000000, 6'b001000);
        run_one("ovf_rz",     32'h3F800000, 32'h40000000, 32'h12345678, 3'd1, 1, 0, 1, 32'h7F7FFFFF, 6'b000011);
        run_one("ovf_ninf",   32'hBF800000, 32'h40000000, 32'h12345678, 3'd3, 1, 0, 0, 32'hFF800000, 6'b010010);
        run_one("unf_away",   32'hBF800000, 32'h40000000, 32'h12345678, 3'd5, 0, 1, 0, 32'h80800000, 6'b000100);
        run_one("unf_pinf",   32'hBF800000, 32'h40000000, 32'h12345678, 3'd2, 0, 1, 0, 32'h80000000, 6'b001100);
        run_one("pass",       32'h3F800000, 32'h40000000, 32'h40000000, 3'd0, 0, 0, 0, 32'h40000000, 6'b000000);
        run_one("ovf_rm7",    32'h3F800000, 32'h40000000, 32'h12345678, 3'd7, 1, 0, 0, 32'h7F800000, 6'b010010);
        run_one("ovf_and_unf",32'h3F800000, 32'h40000000, 32'h12345678, 3'd0, 1, 1, 0, 32'h7F800000, 6'b010010);
        run_one("unf_ninf_p", 32'h3F800000, 32'h40000000, 32'h12345678, 3'd3, 0, 1, 0, 32'h00000000, 6'b001100);
        run_one("subn_flush", 32'h00000001, 32'h40000000, 32'h12345678, 3'd0, 0, 0, 0, 32'h00000000, 6'b001000);
        @(negedge clk);
        check("acc.sticky", 64'(sticky), 64'b111111);
        check("acc.cnt", 64'(exc_cnt), 64'd9);

        // Burst of 4 with a 2-cycle downstream stall in the middle.
        sticky_clr = 1'b1;
        @(negedge clk) sticky_clr = 1'b0;
        sent = 0;
        for (int k = 0; k < 4; k++) exp_q.push_back(32'h40000000 + 32'(k));
        for (int cyc = 0; cyc < 20 && got_q.size() < 4; cyc++) begin
            out_ready = !(cyc == 2 || cyc == 3);
            in_valid  = (sent < 4);
            a = 32'h3F800000; b = 32'h40000000; round = 3'd0; ovf = 0; unf = 0; inexact = 0;
            z_calc = 32'h40000000 + 32'(sent);
            #1;
            if (!out_ready && out_valid) begin
                check($sformatf("stall%0d.in_ready", cyc), 64'(in_ready), 64'd0);
                check($sformatf("stall%0d.z_held", cyc), 64'(z), 64'(exp_q[got_q.size()]));
            end
            if (out_valid && out_ready) got_q.push_back(z);
            @(posedge clk);
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("burst.count", 64'(got_q.size()), 64'd4);
        for (int k = 0; k < 4 && k < got_q.size(); k++)
            check($sformatf("burst.item%0d", k), 64'(got_q[k]), 64'(exp_q[k]));

        // Sticky clear coinciding with a handshake.
        sticky_clr = 1'b1;
        @(negedge clk) sticky_clr = 1'b0;
        for (int k = 0; k < 3; k++)
            run_one($sformatf("nan%0d", k), 32'h7FC00000, 32'h3F800000, 32'h0, 3'd0, 0, 0, 0,
                    32'h7FC00000, 6'b100000);
        run_one("huge4", 32'h3F800000, 32'h40000000, 32'h12345678, 3'd1, 1, 0, 0, 32'h7F7FFFFF, 6'b000010);
        check("pre_clr.sticky", 64'(sticky), 64'b100000);
        check("pre_clr.cnt", 64'(exc_cnt), 64'd3);
        sticky_clr = 1'b1;
        @(posedge clk);
        #1 sticky_clr = 1'b0;
        @(negedge clk);
        check("clr_hs.sticky", 64'(sticky), 64'b000010);
        check("clr_hs.cnt", 64'(exc_cnt), 64'd1);

        // Reset while a stalled result is held.
        @(negedge clk);
        out_ready = 1'b0;
        a = 32'h7F800000; b = 32'h3F800000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("hold.valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst.valid", 64'(out_valid), 64'd0);
        check("mid_rst.z", 64'(z), 64'd0);
        check("mid_rst.flags", 64'(flags()), 64'd0);
        check("mid_rst.sticky", 64'(sticky), 64'd0);
        check("mid_rst.cnt", 64'(exc_cnt), 64'd0);
        @(negedge clk) rst = 1'b0; out_ready = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
